// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the serial feed stages.
package bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit-position counter width for a word of w bits (never below 1).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// Loadable shift register; the tap is the bit at the outgoing end.
module bit_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             tap_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    // Load wins over shift; vacated positions fill with zero.
    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign tap_o = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feed stage with a one-word holding register for gapless streaming.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_data;
    logic             sr_tap;

    assign in_ready = rst & ~hold_full_q;
    assign accept   = in_valid & in_ready;

    bit_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_data),
        .tap_o   (sr_tap)
    );

    // Next-state: IDLE loads directly, SHIFT refills from hold or input at the last bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_data     = in_data;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    sr_load     = 1'b1;
                    sr_data     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (accept) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Output decode from registered state only.
    assign dout_valid = (state_q == ST_SHIFT);
    assign dout       = dout_valid ? sr_tap : IDLE_BIT;
    assign word_start = dout_valid && (cnt_q == '0);
    assign busy       = dout_valid | hold_full_q;

endmodule
